// File: rtl/apb_pkg.sv
// Shared types, widths and helpers for the APB requester.
package apb_pkg;

    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8;
    localparam int unsigned ALIGNBITS      = $clog2(STRB_WIDTH);
    localparam int unsigned TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } apb_req_t;

    // True when the byte address is aligned to the data bus width.
    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ADDR_WIDTH'((1 << ALIGNBITS) - 1);
        return ((addr & mask) == '0);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts stalled ACCESS cycles and flags the cycle that reaches the abort limit.
module apb_wait_timer
    import apb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires on the last permitted stalled cycle so ACCESS lasts exactly TIMEOUT_CYCLES.
    assign o_expired_c = i_tick && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_requester.sv
// APB requester: single-transfer command port to APB SETUP/ACCESS sequencing.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                r_state;
    apb_req_t              r_req;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    state_t                w_state_nxt;
    apb_req_t              w_req_nxt;
    logic                  w_psel_nxt;
    logic                  w_penable_nxt;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_rsp_err_nxt;

`ifdef APB_TIMEOUT_EN
    logic w_timeout_c;

    apb_wait_timer u_wait_timer (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .i_clear     (r_state == SETUP),
        .i_tick      ((r_state == ACCESS) && !PREADY),
        .o_expired_c (w_timeout_c)
    );
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_req_nxt.write = req_write;
                    w_req_nxt.addr  = req_addr;
                    w_req_nxt.wdata = req_wdata;
                    w_req_nxt.strb  = req_write ? req_strb : '0;
                    if (validAlign(req_addr)) begin
                        w_state_nxt = SETUP;
                        w_psel_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ERROR;
                    end
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_rdata_nxt = (!r_req.write && !PSLVERR) ? PRDATA : '0;
`ifdef APB_TIMEOUT_EN
                end else if (w_timeout_c) begin
                    w_state_nxt = ERROR;
`endif
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            ERROR: begin
                w_state_nxt     = IDLE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b1;
                w_rsp_rdata_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_req.write;
    assign PADDR     = r_req.addr;
    assign PWDATA    = r_req.wdata;
    assign PSTRB     = r_req.strb;

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester; honours APB_TIMEOUT_EN.
module tb_apb_requester;
    import apb_pkg::*;

    logic                  PCLK;
    logic                  PRESETn;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_requester dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready} !== 6'b000001) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000001", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, req_ready});
        end
        n_checks++;
        if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%h/%h want 0", PADDR, PWDATA, PSTRB, rsp_rdata);
        end
        PRESETn = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_write();
        PREADY = 1'b1;
        issue(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, req_ready, PADDR, PWDATA, PSTRB} !== {4'b1010, 16'h0010, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("FAIL wr_setup got %b%b%b%b %h %h %h", PSEL, PENABLE, PWRITE, req_ready, PADDR, PWDATA, PSTRB);
        end
        tick();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b110, 16'h0010, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_access got %b%b%b %h %h", PSEL, PENABLE, rsp_valid, PADDR, PWDATA);
        end
        tick();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err, req_ready, rsp_rdata} !== {5'b00101, 32'h0}) begin
            n_fail++; $display("FAIL wr_rsp got %b%b%b%b%b %h want 00101 0", PSEL, PENABLE, rsp_valid, rsp_err, req_ready, rsp_rdata);
        end
        tick();
        n_checks++;
        if ({rsp_valid, PADDR} !== {1'b0, 16'h0010}) begin
            n_fail++; $display("FAIL wr_pulse_hold got %b %h want 0 0010", rsp_valid, PADDR);
        end
        PREADY = 1'b0;
    endtask

    task automatic test_read_wait();
        logic ok;
        issue(1'b0, 16'h0024, 32'h0, 4'hF);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB} !== {3'b100, 16'h0024, 4'h0}) begin
            n_fail++; $display("FAIL rd_setup got %b%b%b %h %h", PSEL, PENABLE, PWRITE, PADDR, PSTRB);
        end
        ok = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            if ({PSEL, PENABLE, rsp_valid, PSTRB, PADDR} !== {3'b110, 4'h0, 16'h0024}) ok = 1'b0;
            if (k == 5) begin
                PREADY = 1'b1;
                PRDATA = 32'h12345678;
            end
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rd_wait_hold got %b want 1", ok);
        end
        tick();
        n_checks++;
        if ({PSEL, rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 32'h12345678}) begin
            n_fail++; $display("FAIL rd_rsp got %b%b%b %h want 010 12345678", PSEL, rsp_valid, rsp_err, rsp_rdata);
        end
        PREADY = 1'b0;
        PRDATA = '0;
    endtask

    task automatic test_misaligned();
        issue(1'b0, 16'h0003, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL mis_err_state got %b%b%b%b want 0000", PSEL, PENABLE, rsp_valid, req_ready);
        end
        tick();
        n_checks++;
        if ({PSEL, rsp_valid, rsp_err, req_ready, rsp_rdata} !== {4'b0111, 32'h0}) begin
            n_fail++; $display("FAIL mis_rsp got %b%b%b%b %h want 0111 0", PSEL, rsp_valid, rsp_err, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        issue(1'b1, 16'h0040, 32'hA5A5A5A5, 4'h3);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, req_ready, PSEL, rsp_rdata} !== {4'b1110, 32'h0}) begin
            n_fail++; $display("FAIL slverr_rsp got %b%b%b%b %h want 1110 0", rsp_valid, rsp_err, req_ready, PSEL, rsp_rdata);
        end
        PSLVERR = 1'b0;
        PRDATA = 32'hCAFEF00D;
        issue(1'b0, 16'h0044, 32'h0, 4'hF);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PSTRB} !== {5'b10001, 16'h0044, 4'h0}) begin
            n_fail++; $display("FAIL b2b_setup got %b%b%b%b%b %h %h", PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PSTRB);
        end
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL b2b_rsp got %b%b %h want 10 cafef00d", rsp_valid, rsp_err, rsp_rdata);
        end
        PREADY = 1'b0;
        PRDATA = '0;
    endtask

    task automatic test_timeout();
        logic ok;
        issue(1'b1, 16'h0080, 32'h11223344, 4'hF);
        tick();
        req_valid = 1'b0;
        tick();
        ok = 1'b1;
`ifdef APB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            tick();
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL to_access_hold got %b want 1", ok);
        end
        tick();
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL to_abort got %b%b%b want 000", PSEL, PENABLE, rsp_valid);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {3'b111, 32'h0}) begin
            n_fail++; $display("FAIL to_rsp got %b%b%b %h want 111 0", rsp_valid, rsp_err, req_ready, rsp_rdata);
        end
`else
        for (int k = 0; k < 110; k++) begin
            tick();
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL nto_wait got %b want 1", ok);
        end
        PREADY = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, PSEL, rsp_rdata} !== {3'b100, 32'h0}) begin
            n_fail++; $display("FAIL nto_rsp got %b%b%b %h want 100 0", rsp_valid, rsp_err, PSEL, rsp_rdata);
        end
`endif
        PREADY = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic ok;
        issue(1'b0, 16'h0050, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_pre got %b%b want 11", PSEL, PENABLE);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL rst_mid_async got %b%b%b%b want 0001", PSEL, PENABLE, rsp_valid, req_ready);
        end
        tick();
        PRESETn = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ({PSEL, rsp_valid, req_ready} !== 3'b001) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_after got %b want 1", ok);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
